// File: rtl/ber_check.sv
// PRBS7/15/23/31 self-synchronising checker with saturating received-bit and
// error counters for the BER display. Hunts for alignment, then free-runs.
module ber_check #(
  parameter int LOCK_MATCH   = 64,
  parameter int WIN_LEN_LOG2 = 10,
  parameter int LOSS_THR     = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PRBS_SEL,
  input  logic        DIN,
  input  logic        DIN_VALID,
  input  logic        CLEAR,
  output logic        LOCKED,
  output logic        LOCK_LOST,
  output logic [57:0] RECV_CNT,
  output logic [63:0] ERR_CNT
);

  // Bit stream: DIN is consumed on every CLK edge with DIN_VALID high; there is
  // no ready/back-pressure, so the source may hold DIN_VALID high every cycle.

  localparam int MW = $clog2(LOCK_MATCH + 1);
  localparam int EW = $clog2(LOSS_THR + 1);

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                  state;
  logic [30:0]             sr;
  logic [MW-1:0]           match_cnt;
  logic [WIN_LEN_LOG2-1:0] win_bits;
  logic [EW-1:0]           win_errs;
  logic [1:0]              prev_sel;
  logic [57:0]             recv_cnt;
  logic [63:0]             err_cnt;
  logic                    lock_lost;

  logic          p;
  logic [30:0]   win_mask;
  logic          win_nz;
  logic          err;
  logic          sel_change;
  logic          recv_full;
  logic          err_full;
  logic          win_end;
  logic [EW-1:0] win_errs_next;

  always_comb begin
    p        = 1'b0;
    win_mask = '0;
    case (PRBS_SEL)
      2'd0:    begin p = sr[6]  ^ sr[5];  win_mask = 31'h0000_007F; end
      2'd1:    begin p = sr[14] ^ sr[13]; win_mask = 31'h0000_7FFF; end
      2'd2:    begin p = sr[22] ^ sr[17]; win_mask = 31'h007F_FFFF; end
      default: begin p = sr[30] ^ sr[27]; win_mask = 31'h7FFF_FFFF; end
    endcase
  end

  assign win_nz     = |(sr & win_mask);
  assign err        = p ^ DIN;
  assign sel_change = (PRBS_SEL != prev_sel);
  assign recv_full  = &recv_cnt;
  assign err_full   = &err_cnt;
  assign win_end    = &win_bits;
  // Window error count saturates at the threshold; beyond it the verdict is fixed.
  assign win_errs_next = (err && (win_errs < EW'(LOSS_THR))) ? win_errs + EW'(1) : win_errs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_HUNT;
      sr        <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      prev_sel  <= PRBS_SEL;
      recv_cnt  <= '0;
      err_cnt   <= '0;
      lock_lost <= 1'b0;
    end else begin
      prev_sel  <= PRBS_SEL;
      lock_lost <= 1'b0;
      if (CLEAR) begin
        state     <= ST_HUNT;
        match_cnt <= '0;
        win_bits  <= '0;
        win_errs  <= '0;
        recv_cnt  <= '0;
        err_cnt   <= '0;
      end else if (sel_change) begin
        // Counters survive a polynomial change; only alignment restarts.
        state     <= ST_HUNT;
        match_cnt <= '0;
        win_bits  <= '0;
        win_errs  <= '0;
      end else if (DIN_VALID) begin
        case (state)
          ST_HUNT: begin
            sr <= {sr[29:0], DIN};
            if (!err && win_nz) begin
              if (match_cnt == MW'(LOCK_MATCH - 1)) begin
                state     <= ST_LOCKED;
                match_cnt <= '0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-run on the prediction so a line error is counted only once.
            sr <= {sr[29:0], p};
            if (!recv_full) begin
              recv_cnt <= recv_cnt + 58'd1;
              if (err && !err_full) err_cnt <= err_cnt + 64'd1;
            end
            if (win_end) begin
              win_bits <= '0;
              win_errs <= '0;
              if (win_errs_next >= EW'(LOSS_THR)) begin
                state     <= ST_HUNT;
                lock_lost <= 1'b1;
              end
            end else begin
              win_bits <= win_bits + 1'b1;
              win_errs <= win_errs_next;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign LOCKED    = (state == ST_LOCKED);
  assign LOCK_LOST = lock_lost;
  assign RECV_CNT  = recv_cnt;
  assign ERR_CNT   = err_cnt;

endmodule

// File: tb/tb_ber_check.sv
// Bench for ber_check: random-seeded PRBS streams with injected errors, checked
// against a history-based reference checker model kept in the bench.
module tb_ber_check;

  localparam logic [57:0] RECV_MAX = '1;
  localparam logic [63:0] ERR_MAX  = '1;
  localparam int          LOCK_MATCH = 64;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  prbs_sel;
  logic        din;
  logic        din_valid;
  logic        clear;
  logic        locked;
  logic        lock_lost;
  logic [57:0] recv_cnt;
  logic [63:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_lost = 0;

  always #5 clk = ~clk;

  ber_check dut (
    .CLK       (clk),
    .RST       (rst),
    .PRBS_SEL  (prbs_sel),
    .DIN       (din),
    .DIN_VALID (din_valid),
    .CLEAR     (clear),
    .LOCKED    (locked),
    .LOCK_LOST (lock_lost),
    .RECV_CNT  (recv_cnt),
    .ERR_CNT   (err_cnt)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int tap_a(input logic [1:0] s);
    case (s)
      2'd0:    return 7;
      2'd1:    return 15;
      2'd2:    return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tap_b(input logic [1:0] s);
    case (s)
      2'd0:    return 6;
      2'd1:    return 14;
      2'd2:    return 18;
      default: return 28;
    endcase
  endfunction

  // ---------------- stimulus generator ----------------
  logic [30:0] gen_sr;
  logic [1:0]  gen_sel;

  task automatic gen_seed(input logic [1:0] s, input logic [30:0] seed);
    logic [30:0] mask;
    mask    = (31'd1 << tap_a(s)) - 31'd1;
    gen_sel = s;
    gen_sr  = seed & mask;
    if (gen_sr == '0) gen_sr = 31'd1;
  endtask

  task automatic gen_bit(output logic b);
    b      = gen_sr[tap_a(gen_sel)-1] ^ gen_sr[tap_b(gen_sel)-1];
    gen_sr = {gen_sr[29:0], b};
  endtask

  // ---------------- reference model ----------------
  // History queue of bits the checker has seen (newest at the back); taps index
  // back into it instead of modelling a shift register.
  bit          m_hist[$];
  bit          m_locked;
  int          m_match;
  logic [57:0] m_recv;
  logic [63:0] m_err;
  int          m_wbits;
  int          m_werrs;
  logic [1:0]  m_sel;
  int          m_lost;

  function automatic bit m_tap(input int k);
    return (m_hist.size() >= k) ? m_hist[m_hist.size()-k] : 1'b0;
  endfunction

  task automatic m_reset();
    m_hist.delete();
    m_locked = 0; m_match = 0; m_recv = '0; m_err = '0;
    m_wbits = 0; m_werrs = 0; m_sel = prbs_sel;
  endtask

  task automatic m_step(input logic d);
    int a;
    bit p, nz, e;
    a = tap_a(m_sel);
    p = m_tap(a) ^ m_tap(tap_b(m_sel));
    if (!m_locked) begin
      nz = 0;
      for (int k = 1; k <= a; k++) if (m_tap(k)) nz = 1;
      m_hist.push_back(d);
      if (p == d && nz) begin
        m_match++;
        if (m_match == LOCK_MATCH) begin
          m_locked = 1; m_match = 0; m_wbits = 0; m_werrs = 0;
        end
      end else begin
        m_match = 0;
      end
    end else begin
      m_hist.push_back(p);
      e = p ^ d;
      if (m_recv != RECV_MAX) begin
        m_recv = m_recv + 58'd1;
        if (e && m_err != ERR_MAX) m_err = m_err + 64'd1;
      end
      m_wbits++;
      if (e && m_werrs < 256) m_werrs++;
      if (m_wbits == 1024) begin
        if (m_werrs >= 256) begin
          m_locked = 0; m_match = 0; m_lost++;
        end
        m_wbits = 0; m_werrs = 0;
      end
    end
    while (m_hist.size() > 31) void'(m_hist.pop_front());
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic d, input logic v, input logic c);
    bit chg;
    din = d; din_valid = v; clear = c;
    @(posedge clk);
    chg = (prbs_sel != m_sel);
    if (rst) begin
      m_reset();
    end else begin
      m_sel = prbs_sel;
      if (c) begin
        m_locked = 0; m_match = 0; m_wbits = 0; m_werrs = 0; m_recv = '0; m_err = '0;
      end else if (chg) begin
        m_locked = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
      end else if (v) begin
        m_step(d);
      end
    end
    #1;
    if (lock_lost) dut_lost++;
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic set_sel(input logic [1:0] s);
    prbs_sel = s;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic hunt_model(input int limit);
    logic b;
    for (int i = 0; i < limit && !m_locked; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
    end
  endtask

  logic [57:0] exp_q[$];

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    rst = 1'b0;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    n_checks++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost: got %0b expected 0", lock_lost); end
    n_checks++; if (recv_cnt !== 58'd0) begin n_fail++; $display("FAIL reset_recv: got %0d expected 0", recv_cnt); end
    n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_prbs7_lock();
    logic        b;
    logic [57:0] e;
    int          lock_mis = 0;
    int          cnt_mis  = 0;
    gen_seed(2'd0, 31'h7F);
    for (int i = 0; i < 71; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
      if (locked !== m_locked) lock_mis++;
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs7_lock_by_71: got %0b expected 1", locked); end
    n_checks++; if (lock_mis != 0) begin n_fail++; $display("FAIL prbs7_lock_track: %0d cycles differ from model, expected 0", lock_mis); end
    for (int i = 0; i < 300; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
      exp_q.push_back(m_recv);
      e = exp_q.pop_front();
      if (recv_cnt !== e) cnt_mis++;
      if (err_cnt !== 64'd0) cnt_mis++;
    end
    n_checks++; if (cnt_mis != 0) begin n_fail++; $display("FAIL prbs7_per_bit_count: %0d mismatching cycles, expected 0", cnt_mis); end
    n_checks++; if (recv_cnt !== m_recv) begin n_fail++; $display("FAIL prbs7_recv: got %0d expected %0d", recv_cnt, m_recv); end
    n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL prbs7_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_prbs15_errors();
    logic b;
    int   p1, p2, p3, lost0;
    int   lock_mis = 0;
    set_sel(2'd1);
    drive(1'b0, 1'b0, 1'b1);
    gen_seed(2'd1, 31'($urandom));
    hunt_model(300);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs15_lock: got %0b expected 1", locked); end
    p1 = int'($urandom_range(100, 1500));
    p2 = int'($urandom_range(2000, 3000));
    p3 = int'($urandom_range(3500, 4900));
    lost0 = dut_lost;
    for (int i = 0; i < 5000; i++) begin
      gen_bit(b);
      drive(b ^ ((i == p1) || (i == p2) || (i == p3)), 1'b1, 1'b0);
      if (locked !== 1'b1) lock_mis++;
    end
    n_checks++; if (recv_cnt !== 58'd5000) begin n_fail++; $display("FAIL prbs15_recv: got %0d expected 5000", recv_cnt); end
    n_checks++; if (err_cnt !== 64'd3) begin n_fail++; $display("FAIL prbs15_err: got %0d expected 3", err_cnt); end
    n_checks++; if (lock_mis != 0) begin n_fail++; $display("FAIL prbs15_stay_locked: %0d unlocked cycles, expected 0", lock_mis); end
    n_checks++; if (dut_lost != lost0) begin n_fail++; $display("FAIL prbs15_no_lost: got %0d pulses expected 0", dut_lost - lost0); end
  endtask

  task automatic test_all_zero();
    int hi = 0;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) hi++;
    end
    n_checks++; if (hi != 0) begin n_fail++; $display("FAIL zero_no_lock: %0d locked cycles, expected 0", hi); end
    n_checks++; if (recv_cnt !== 58'd0) begin n_fail++; $display("FAIL zero_recv: got %0d expected 0", recv_cnt); end
    n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL zero_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_prbs31_loss();
    logic b;
    int   lost0, fall_at;
    set_sel(2'd3);
    drive(1'b0, 1'b0, 1'b1);
    gen_seed(2'd3, 31'($urandom));
    hunt_model(300);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs31_lock: got %0b expected 1", locked); end
    lost0 = dut_lost;
    for (int i = 0; i < 100; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
    end
    fall_at = -1;
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (fall_at < 0 && locked !== 1'b1) fall_at = i;
    end
    n_checks++; if (fall_at < 0 || fall_at >= 2048) begin n_fail++; $display("FAIL prbs31_fall: fell at random bit %0d expected within 2048", fall_at); end
    n_checks++; if (dut_lost - lost0 != 1) begin n_fail++; $display("FAIL prbs31_lost_once: got %0d pulses expected 1", dut_lost - lost0); end
    n_checks++; if (recv_cnt !== 58'd1024) begin n_fail++; $display("FAIL prbs31_recv_at_loss: got %0d expected 1024", recv_cnt); end
    n_checks++; if (err_cnt !== m_err) begin n_fail++; $display("FAIL prbs31_err_at_loss: got %0d expected %0d", err_cnt, m_err); end
    for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    n_checks++; if (recv_cnt !== m_recv || m_recv !== 58'd1024) begin n_fail++; $display("FAIL prbs31_recv_hold: got %0d expected 1024", recv_cnt); end
    n_checks++; if (err_cnt !== m_err) begin n_fail++; $display("FAIL prbs31_err_hold: got %0d expected %0d", err_cnt, m_err); end
    hunt_model(300);
    for (int i = 0; i < 50; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prbs31_relock: got %0b expected 1", locked); end
    n_checks++; if (recv_cnt !== 58'd1074) begin n_fail++; $display("FAIL prbs31_recv_resume: got %0d expected 1074", recv_cnt); end
  endtask

  task automatic test_clear_locked();
    logic b;
    int   lost0, n;
    set_sel(2'd2);
    drive(1'b0, 1'b0, 1'b1);
    gen_seed(2'd2, 31'($urandom));
    hunt_model(300);
    for (int i = 0; i < 100; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
    end
    n_checks++; if (recv_cnt !== 58'd100) begin n_fail++; $display("FAIL clr_pre_recv: got %0d expected 100", recv_cnt); end
    lost0 = dut_lost;
    gen_bit(b);
    drive(b, 1'b1, 1'b1);
    n_checks++; if (recv_cnt !== 58'd0) begin n_fail++; $display("FAIL clr_recv: got %0d expected 0", recv_cnt); end
    n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL clr_err: got %0d expected 0", err_cnt); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked: got %0b expected 0", locked); end
    n_checks++; if (dut_lost != lost0) begin n_fail++; $display("FAIL clr_no_lost: got %0d pulses expected 0", dut_lost - lost0); end
    n = 0;
    while (locked !== 1'b1 && n < 87) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
      n++;
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL clr_relock: not locked after %0d bits, expected within 87", n); end
    n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL clr_relock_model: got %0b expected %0b", locked, m_locked); end
  endtask

  task automatic test_saturation();
    logic b;
    for (int i = 0; i < 10; i++) begin
      gen_bit(b);
      drive(b, 1'b1, 1'b0);
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_pre_locked: got %0b expected 1", locked); end
    @(negedge clk);
    dut.recv_cnt <= RECV_MAX - 58'd1;
    dut.err_cnt  <= 64'd5;
    m_recv = RECV_MAX - 58'd1;
    m_err  = 64'd5;
    gen_bit(b);
    drive(~b, 1'b1, 1'b0);
    n_checks++; if (recv_cnt !== RECV_MAX) begin n_fail++; $display("FAIL sat_recv_first: got %0h expected %0h", recv_cnt, RECV_MAX); end
    n_checks++; if (err_cnt !== 64'd6) begin n_fail++; $display("FAIL sat_err_first: got %0d expected 6", err_cnt); end
    gen_bit(b);
    drive(b, 1'b1, 1'b0);
    gen_bit(b);
    drive(~b, 1'b1, 1'b0);
    n_checks++; if (recv_cnt !== RECV_MAX || m_recv !== RECV_MAX) begin n_fail++; $display("FAIL sat_recv_frozen: got %0h expected %0h", recv_cnt, RECV_MAX); end
    n_checks++; if (err_cnt !== 64'd6 || m_err !== 64'd6) begin n_fail++; $display("FAIL sat_err_frozen: got %0d expected 6", err_cnt); end
    @(negedge clk);
    dut.recv_cnt <= 58'd100;
    dut.err_cnt  <= ERR_MAX;
    m_recv = 58'd100;
    m_err  = ERR_MAX;
    repeat (2) begin
      gen_bit(b);
      drive(~b, 1'b1, 1'b0);
    end
    n_checks++; if (recv_cnt !== 58'd102) begin n_fail++; $display("FAIL sat_err_indep_recv: got %0d expected 102", recv_cnt); end
    n_checks++; if (err_cnt !== ERR_MAX) begin n_fail++; $display("FAIL sat_err_indep_err: got %0h expected %0h", err_cnt, ERR_MAX); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %0b expected 0", locked); end
    n_checks++; if (recv_cnt !== 58'd0) begin n_fail++; $display("FAIL midrst_recv: got %0d expected 0", recv_cnt); end
    n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL midrst_err: got %0d expected 0", err_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    clear     = 1'b0;
    prbs_sel  = 2'd0;
    m_lost    = 0;
    m_reset();
    test_reset();
    test_prbs7_lock();
    test_prbs15_errors();
    test_all_zero();
    test_prbs31_loss();
    test_clear_locked();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
